// File: rtl/polar_enc_pkg.sv
// Shared types and constants for the polar encoder datapath.
// Imported by the frame RAM read streamer and its skid FIFO users.
package polar_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } rd_state_e;

    localparam int RD_FIFO_DEPTH = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ad_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Head word is presented straight from the storage registers.
module ad_stream_fifo #(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // A full FIFO with no pop must never see a push; the producer's credit
    // accounting is what guarantees this.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full && !pop)
    );

endmodule

// File: rtl/ad_mem_rd_stream.sv
// Frame RAM read streamer: issues FRAME_LEN wrapped reads from base_addr
// and turns the 1-cycle RAM latency into a valid/ready stream with m_last.
module ad_mem_rd_stream
    import polar_enc_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 5,
    parameter int FRAME_LEN     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     reb,
    output logic [ADDRESS_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0]    doutb,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_last
);

    localparam int CW = cnt_width(FRAME_LEN);
    localparam int FW = $clog2(RD_FIFO_DEPTH + 1);
    localparam int SW = FW + 1;

    rd_state_e                state;
    rd_state_e                state_nx;
    logic [CW-1:0]            iss_cnt;
    logic [CW-1:0]            iss_cnt_nx;
    logic [CW-1:0]            pop_cnt;
    logic [CW-1:0]            pop_cnt_nx;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH-1:0] base_nx;
    logic [ADDRESS_WIDTH-1:0] addr_nx;
    logic                     reb_nx;
    logic                     reb_last;
    logic                     reb_last_nx;
    logic                     rvalid;
    logic                     rlast;
    logic [FW-1:0]            fcount;
    logic                     fifo_empty;
    logic [DATA_WIDTH:0]      head;
    logic [SW-1:0]            used;
    logic                     can_issue;
    logic                     hs;
    logic                     last_hs;

    assign m_valid = !fifo_empty;
    assign {m_last, m_data} = head;
    assign hs      = m_valid && m_ready;
    assign last_hs = hs && (pop_cnt == CW'(FRAME_LEN - 1));
    assign busy    = (state == ISSUE) || (state == DRAIN);
    assign done    = (state == DONE);

    // Words held plus reads still in the RAM pipe; a pop this cycle is not
    // counted, which keeps the check free of any m_ready timing path.
    assign used = SW'(fcount) + SW'(rvalid) + SW'(reb);
    assign can_issue = (iss_cnt < CW'(FRAME_LEN))
                    && (used < SW'(RD_FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        base_nx     = base_q;
        iss_cnt_nx  = iss_cnt;
        pop_cnt_nx  = hs ? pop_cnt + CW'(1) : pop_cnt;
        reb_nx      = 1'b0;
        addr_nx     = addrb;
        reb_last_nx = 1'b0;
        unique case (state)
            IDLE: begin
                pop_cnt_nx = '0;
                iss_cnt_nx = '0;
                if (start) begin
                    // First read goes out on the next cycle as index 0.
                    state_nx    = ISSUE;
                    base_nx     = base_addr;
                    iss_cnt_nx  = CW'(1);
                    reb_nx      = 1'b1;
                    addr_nx     = base_addr;
                    reb_last_nx = (FRAME_LEN == 1);
                end
            end
            ISSUE: begin
                if (iss_cnt == CW'(FRAME_LEN)) begin
                    state_nx = DRAIN;
                end else if (can_issue) begin
                    reb_nx      = 1'b1;
                    addr_nx     = base_q + ADDRESS_WIDTH'(iss_cnt);
                    reb_last_nx = (iss_cnt == CW'(FRAME_LEN - 1));
                    iss_cnt_nx  = iss_cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            iss_cnt  <= '0;
            pop_cnt  <= '0;
            reb      <= 1'b0;
            addrb    <= '0;
            reb_last <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
        end else begin
            base_q   <= base_nx;
            iss_cnt  <= iss_cnt_nx;
            pop_cnt  <= pop_cnt_nx;
            reb      <= reb_nx;
            addrb    <= addr_nx;
            reb_last <= reb_last_nx;
            rvalid   <= reb;
            rlast    <= reb_last;
        end
    end

    ad_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rvalid),
        .din   ({rlast, doutb}),
        .pop   (hs),
        .dout  (head),
        .empty (fifo_empty),
        .count (fcount)
    );

endmodule

// File: tb/tb_ad_mem_rd_stream.sv
// Bench for ad_mem_rd_stream: RAM model, queue-based frame model,
// per-cycle compare process, plus a FRAME_LEN=1 instance.
module tb_ad_mem_rd_stream;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int FL = 32;
    localparam int RD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          m_ready;
    logic [AW-1:0] base_addr;
    logic          busy, done, reb, m_valid, m_last;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb, m_data;

    logic          start1;
    logic          m_ready1;
    logic [AW-1:0] base_addr1;
    logic          busy1, done1, reb1, m_valid1, m_last1;
    logic [AW-1:0] addrb1;
    logic [DW-1:0] doutb1, m_data1;

    logic [DW-1:0] mem [RD];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rmode = 0;

    ad_mem_rd_stream #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .FRAME_LEN     (FL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .reb       (reb),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    ad_mem_rd_stream #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .FRAME_LEN     (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .base_addr (base_addr1),
        .busy      (busy1),
        .done      (done1),
        .reb       (reb1),
        .addrb     (addrb1),
        .doutb     (doutb1),
        .m_valid   (m_valid1),
        .m_ready   (m_ready1),
        .m_data    (m_data1),
        .m_last    (m_last1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (reb) doutb <= mem[addrb];
    always @(posedge clk) if (reb1) doutb1 <= mem[addrb1];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Frame model: the expected word list is built from the RAM image at
    // the accepted start; the DUT must deliver it in order, once each.
    logic [DW:0]   expq [$];
    int            addr_log [$];
    int            phase = 0;
    int            n_iss = 0;
    int            n_pop = 0;
    int            s_cyc = 0;
    int            first_at = -1;
    int            done_cyc = 0;
    int            frames = 0;
    logic [AW-1:0] m_base = '0;
    logic          stall = 1'b0;
    logic [DW:0]   held = '0;
    logic [DW-1:0] f_first = '0;
    logic [DW-1:0] f_lastw = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_reb", reb, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_done", done, 0);
            phase = 0;
            expq.delete();
            n_iss = 0;
            n_pop = 0;
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_word", {m_last, m_data}, held);
            end
            stall = 1'b0;
            case (phase)
                0: begin
                    chk("idle_busy", busy, 0);
                    chk("idle_reb", reb, 0);
                    chk("idle_valid", m_valid, 0);
                    chk("idle_done", done, 0);
                    if (start) begin
                        phase = 1;
                        m_base = base_addr;
                        s_cyc = cyc;
                        n_iss = 0;
                        n_pop = 0;
                        first_at = -1;
                        addr_log.delete();
                        for (int i = 0; i < FL; i++) begin
                            expq.push_back({1'(i == FL - 1),
                                            mem[(int'(base_addr) + i) % RD]});
                        end
                    end
                end
                1: begin
                    chk("run_busy", busy, 1);
                    chk("run_done", done, 0);
                    if (reb) begin
                        chk("addrb", addrb, (int'(m_base) + n_iss) % RD);
                        if (n_iss == 0) chk("reb_latency", cyc - s_cyc, 1);
                        addr_log.push_back(int'(addrb));
                        n_iss++;
                        chk("read_count", n_iss <= FL, 1);
                    end
                    chk("outstanding", (n_iss - n_pop) <= 4, 1);
                    if (m_valid) begin
                        if (first_at < 0) begin
                            first_at = cyc;
                            chk("beat_latency", cyc - s_cyc, 3);
                        end
                        if (expq.size() == 0) begin
                            chk("extra_beat", 1, 0);
                        end else begin
                            chk("m_data", m_data, expq[0][DW-1:0]);
                            chk("m_last", m_last, expq[0][DW]);
                            if (m_ready) begin
                                if (n_pop == 0) f_first = m_data;
                                f_lastw = m_data;
                                void'(expq.pop_front());
                                n_pop++;
                                if (expq.size() == 0) phase = 2;
                            end else begin
                                stall = 1'b1;
                                held = {m_last, m_data};
                            end
                        end
                    end
                end
                default: begin
                    chk("done_pulse", done, 1);
                    chk("done_busy", busy, 0);
                    chk("done_valid", m_valid, 0);
                    chk("done_reb", reb, 0);
                    done_cyc = cyc;
                    frames++;
                    phase = 0;
                end
            endcase
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = AW'($urandom);
    endtask

    task automatic wait_frame(input string nm);
        int f0;
        int k;
        f0 = frames;
        k = 0;
        while (frames == f0 && k < 4000) begin
            tick();
            k++;
        end
        chk(nm, frames != f0, 1);
    endtask

    initial begin
        int f0;
        int k;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        start1 = 1'b0;
        base_addr1 = '0;
        m_ready1 = 1'b1;
        for (int i = 0; i < RD; i++) mem[i] = DW'(16'h1000 + i);
        #12;
        chk("reset_m_data", m_data, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_addrb", addrb, 0);
        tick();
        rst = 1'b0;
        tick();

        // Basic frame at full rate
        rmode = 0;
        start_frame(0);
        wait_frame("basic_frame_end");
        chk("basic_first", f_first, 16'h1000);
        chk("basic_last", f_lastw, 16'h101F);
        chk("basic_beats", n_pop, 32);
        chk("basic_span", done_cyc - s_cyc, 35);

        // Address wrap
        start_frame(30);
        wait_frame("wrap_frame_end");
        chk("wrap_a0", addr_log[0], 30);
        chk("wrap_a1", addr_log[1], 31);
        chk("wrap_a2", addr_log[2], 0);
        chk("wrap_a3", addr_log[3], 1);
        chk("wrap_first", f_first, 16'h101E);
        chk("wrap_last", f_lastw, 16'h101D);

        // Reset after the 10th beat, then a clean frame from 8
        start_frame(3);
        k = 0;
        while (n_pop < 10 && k < 200) begin
            tick();
            k++;
        end
        chk("rst_reach_10", n_pop >= 10, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_reb", reb, 0);
        chk("async_addrb", addrb, 0);
        chk("async_valid", m_valid, 0);
        chk("async_data", m_data, 0);
        chk("async_last", m_last, 0);
        chk("async_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        start_frame(8);
        wait_frame("after_rst_end");
        chk("after_rst_first", f_first, 16'h1008);
        chk("after_rst_last", f_lastw, 16'h1007);
        chk("after_rst_beats", n_pop, 32);

        // Random RAM image from here on
        for (int i = 0; i < RD; i++) mem[i] = DW'($urandom);

        // Backpressure pattern 1,0,0,1
        rmode = 1;
        start_frame(13);
        wait_frame("bp_frame_end");
        chk("bp_beats", n_pop, 32);

        // m_ready held low for 10 cycles
        rmode = 3;
        start_frame(20);
        repeat (10) tick();
        chk("hold_reads", n_iss, 4);
        chk("hold_beats", n_pop, 0);
        rmode = 1;
        wait_frame("hold_frame_end");

        // Start pulses while busy are ignored
        f0 = frames;
        start_frame(2);
        repeat (5) tick();
        base_addr = 9;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (n_iss < FL && k < 500) begin
            tick();
            k++;
        end
        chk("drain_reach", n_iss, FL);
        base_addr = 17;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_in_drain", busy, 1);
        wait_frame("busy_frame_end");
        repeat (5) tick();
        chk("one_done_only", frames - f0, 1);
        chk("idle_after", busy, 0);
        start_frame(25);
        wait_frame("next_frame_end");
        chk("next_first", f_first, mem[25]);

        // Random traffic
        rmode = 2;
        for (int f = 0; f < 4; f++) begin
            start_frame(AW'($urandom));
            wait_frame("rand_frame_end");
            chk("rand_beats", n_pop, 32);
        end

        // FRAME_LEN=1 instance
        base_addr1 = 7;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("one_reb", reb1, 1);
        chk("one_addr", addrb1, 7);
        chk("one_busy", busy1, 1);
        tick();
        chk("one_reb_off", reb1, 0);
        chk("one_valid_early", m_valid1, 0);
        tick();
        chk("one_valid", m_valid1, 1);
        chk("one_last", m_last1, 1);
        chk("one_data", m_data1, mem[7]);
        chk("one_reb_quiet", reb1, 0);
        tick();
        chk("one_done", done1, 1);
        chk("one_done_busy", busy1, 0);
        chk("one_done_valid", m_valid1, 0);
        tick();
        chk("one_done_off", done1, 0);

        chk("end_phase", phase, 0);
        chk("end_queue", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ad_mem_rd_stream.md
Name: ad_mem_rd_stream

Overview:
- Downstream consumer of the encoder's dual-port frame RAM (read port: reb/addrb/doutb).
- On a start pulse, reads FRAME_LEN consecutive words from base_addr, wrapping modulo the RAM depth.
- Absorbs the RAM's 1-cycle registered read latency and presents the words as a valid/ready stream, with last-word marking, to the next polar encode stage.
- Full throughput of 1 word/cycle; downstream backpressure never drops a word.

Parameters:
- DATA_WIDTH, 16, word width; must match the RAM.
- ADDRESS_WIDTH, 5, RAM address width; RAM depth = 2**ADDRESS_WIDTH.
- FRAME_LEN, 32, words per frame; legal range 1..2**ADDRESS_WIDTH.

Ports:
- clk  in  1  single clock; also drives the RAM read port (clkb).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- base_addr  in  ADDRESS_WIDTH  first read address; captured with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  1-cycle pulse after the last word handshakes.
- reb  out  1  RAM read enable.
- addrb  out  ADDRESS_WIDTH  RAM read address.
- doutb  in  DATA_WIDTH  RAM read data, valid the cycle after reb.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  high with the final word of the frame.

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, all counters 0, FIFO emptied.
- States:
  - IDLE: start=1 → ISSUE; captures base_addr; issue and pop counters cleared.
  - ISSUE: reads are issued under the credit rule. Once FRAME_LEN reads have been issued → DRAIN.
  - DRAIN: no new reads. Leaves when the FRAME_LEN-th word handshakes (m_valid & m_ready) → DONE.
  - DONE: done=1 for exactly one cycle; busy=0 that cycle → IDLE.
- start while not IDLE: ignored, no queuing.
- reb/addrb are registered outputs:
  - reb=1 in cycle t returns doutb in cycle t+1.
  - doutb is written into the internal FIFO at the end of cycle t+1.
- Latency: start sampled high at edge k gives:
  - reb=1, addrb=base_addr in cycle k+1.
  - m_valid=1 with that word in cycle k+3.
- Skid FIFO: depth 4 (localparam), first-word-fall-through registered output.
  - m_valid = FIFO not empty.
  - m_data and m_last come from the FIFO head.
- Credit rule: a read is issued in cycle c only if (fifo_count + inflight) < 4.
  - inflight = reads issued whose data is not yet written to the FIFO; 0..2.
  - A same-cycle pop is not credited.
  - With m_ready held at 1 this sustains 1 word/cycle after fill.
- Address: addrb = (base_addr + issue_cnt) mod 2**ADDRESS_WIDTH. Natural wrap, no error.
- m_last is tagged on the word from issue index FRAME_LEN-1 and travels with it through the FIFO.
- m_valid, once high, stays high with m_data stable until a handshake. It never drops without a pop.
- Simultaneous FIFO push and pop: count unchanged, both occur.
- FIFO overflow is impossible by the credit rule; implement an assertion for it.
- FRAME_LEN=1: one read is issued, and m_valid & m_last arrive together.
- Reset mid-frame: immediate abort. In-flight RAM data is discarded; the next start begins a clean frame.
- The RAM write side is outside this block. Callers must not write the frame region while busy.

Decomposition:
- Shared package (polar_enc_pkg) holds:
  - State typedef: IDLE, ISSUE, DRAIN, DONE.
  - Constant RD_FIFO_DEPTH=4.
  - Width function for counters: clog2(FRAME_LEN+1).
- One sub-module: ad_stream_fifo.
  - Parameterized WIDTH/DEPTH, synchronous FWFT FIFO with count output.
  - Stores {m_last, data}.
- FSM, credit counter and address generation stay in ad_mem_rd_stream.

Test Plan:
- Basic frame: RAM preloaded with word[i]=16'h1000+i; start with base_addr=0 and m_ready=1 → 32 consecutive m_valid beats 16'h1000..16'h101F.
  - First beat at start edge+3.
  - m_last only on 16'h101F.
  - done pulse 1 cycle after it.
- Wrap-around: base_addr=5'd30, FRAME_LEN=4 → addrb sequence 30,31,0,1; data order matches.
- Backpressure: m_ready toggles 1,0,0,1 repeating; also held low for 10 cycles.
  - No loss, duplication or reorder.
  - m_data stable while stalled.
  - (fifo_count+inflight) never exceeds 4.
  - reb stops after at most 4 outstanding.
- Start while busy: second start pulses during ISSUE and DRAIN are ignored.
  - Exactly one done.
  - busy stays high throughout.
  - The next start after done is accepted.
- Reset mid-frame: rst asserted after the 10th beat.
  - Outputs are 0 immediately, asynchronously.
  - A new start with base_addr=8 streams a complete clean frame from address 8.
- FRAME_LEN=1 build: one reb; one beat with m_valid=m_last=1; done next cycle.
